// File: rtl/sim_console_pkg.sv
// Shared types and constants for the simulation console / sim-control AXI write slave.
package sim_console_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [1:0]  BURST_INCR   = 2'b01;

    localparam logic [63:0] MAGIC_PASS   = 64'h0000_0004_4433_3222;
    localparam logic [63:0] MAGIC_FAIL   = 64'h0000_0023_8234_8720;

    localparam logic [39:0] CON_ADDR_DEF  = 40'h00_9000_0000;
    localparam logic [39:0] CTRL_ADDR_DEF = 40'h00_9000_0010;

endpackage

// File: rtl/sim_console_fifo.sv
// Synchronous FIFO for console characters; push while full is honoured only with a same-cycle pop.
module sim_console_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/axi_sim_console_slave.sv
// AXI4 write-only slave for the simulation-peripheral window: console character sink and
// sim-control (pass/fail) register, one outstanding transaction at a time.
module axi_sim_console_slave
    import sim_console_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 40,
    parameter int unsigned        DATA_W     = 128,
    parameter int unsigned        ID_W       = 8,
    parameter int unsigned        FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  CON_ADDR   = ADDR_W'(CON_ADDR_DEF),
    parameter logic [ADDR_W-1:0]  CTRL_ADDR  = ADDR_W'(CTRL_ADDR_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_W-1:0]     awaddr_i,
    input  logic [ID_W-1:0]       awid_i,
    input  logic [3:0]            awlen_i,
    input  logic [1:0]            awburst_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic                  wlast_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [ID_W-1:0]       bid_o,
    output logic [1:0]            bresp_o,
    output logic                  char_valid_o,
    input  logic                  char_ready_i,
    output logic [7:0]            char_data_o,
    output logic                  sim_done_o,
    output logic                  sim_pass_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e          state_q, state_d;
    logic            rdy_q;
    logic            con_q, con_d;
    logic            ctl_q, ctl_d;
    logic            err_q, err_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic            aw_hs;
    logic            w_hs;
    logic            lane_ok;
    logic [7:0]      lane_char;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            len_burst_ok;

    // A console beat carries exactly one full 32-bit lane; the character is its low byte.
    always_comb begin
        lane_ok   = 1'b0;
        lane_char = '0;
        for (int k = 0; k < 4; k++) begin
            if (wstrb_i == (STRB_W'(4'hF) << (4 * k))) begin
                lane_ok   = 1'b1;
                lane_char = wdata_i[32 * k +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        con_d        = con_q;
        ctl_d        = ctl_q;
        err_d        = err_q;
        bid_d        = bid_q;
        done_d       = done_q;
        pass_d       = pass_q;
        wready_o     = 1'b0;
        char_valid_o = !fifo_empty;
        fifo_pop     = char_valid_o && char_ready_i;
        awready_o    = rdy_q && (state_q == IDLE);
        bvalid_o     = (state_q == RESP);
        bresp_o      = err_q ? RESP_SLVERR : RESP_OKAY;
        bid_o        = bid_q;
        sim_done_o   = done_q;
        sim_pass_o   = pass_q;
        aw_hs        = awvalid_i && awready_o;
        len_burst_ok = (awlen_i == 4'd0) && (awburst_i == BURST_INCR);

        unique case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    con_d   = len_burst_ok && (awaddr_i == CON_ADDR);
                    ctl_d   = len_burst_ok && (awaddr_i == CTRL_ADDR);
                    err_d   = !(con_d || ctl_d);
                    bid_d   = awid_i;
                    state_d = DATA;
                end
            end
            DATA: begin
                wready_o = con_q ? (!fifo_full || fifo_pop) : 1'b1;
                if (wvalid_i && wready_o && wlast_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        w_hs      = (state_q == DATA) && wvalid_i && wready_o;
        fifo_push = w_hs && con_q && lane_ok;

        // First magic value wins; later terminal writes are ignored.
        if (w_hs && ctl_q && (wstrb_i[7:0] == 8'hFF) && !done_q) begin
            if (wdata_i[63:0] == MAGIC_PASS) begin
                done_d = 1'b1;
                pass_d = 1'b1;
            end else if (wdata_i[63:0] == MAGIC_FAIL) begin
                done_d = 1'b1;
                pass_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            con_q   <= 1'b0;
            ctl_q   <= 1'b0;
            err_q   <= 1'b0;
            bid_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            con_q   <= con_d;
            ctl_q   <= ctl_d;
            err_q   <= err_d;
            bid_q   <= bid_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    sim_console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .push_i  (fifo_push),
        .data_i  (lane_char),
        .pop_i   (fifo_pop),
        .data_o  (char_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_axi_sim_console_slave.sv
// Self-checking bench for axi_sim_console_slave: directed vector table, corner sequences,
// and randomized transactions against a behavioural model.
module tb_axi_sim_console_slave;

    localparam logic [39:0]  CON   = 40'h00_9000_0000;
    localparam logic [39:0]  CTRL  = 40'h00_9000_0010;
    localparam logic [39:0]  BAD   = 40'h00_9000_0020;
    localparam logic [63:0]  PASSV = 64'h4_4433_3222;
    localparam logic [63:0]  FAILV = 64'h23_8234_8720;
    localparam int           TMO   = 40;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [39:0]  awaddr = '0;
    logic [7:0]   awid = '0;
    logic [3:0]   awlen = '0;
    logic [1:0]   awburst = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [127:0] wdata = '0;
    logic [15:0]  wstrb = '0;
    logic         wlast = 1'b0;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [7:0]   bid;
    logic [1:0]   bresp;
    logic         char_valid;
    logic         char_ready = 1'b0;
    logic [7:0]   char_data;
    logic         sim_done;
    logic         sim_pass;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [7:0] exp_q[$];
    logic       m_done = 1'b0;
    logic       m_pass = 1'b0;

    always #5 clk = ~clk;

    axi_sim_console_slave dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .awvalid_i    (awvalid),
        .awready_o    (awready),
        .awaddr_i     (awaddr),
        .awid_i       (awid),
        .awlen_i      (awlen),
        .awburst_i    (awburst),
        .wvalid_i     (wvalid),
        .wready_o     (wready),
        .wdata_i      (wdata),
        .wstrb_i      (wstrb),
        .wlast_i      (wlast),
        .bvalid_o     (bvalid),
        .bready_i     (bready),
        .bid_o        (bid),
        .bresp_o      (bresp),
        .char_valid_o (char_valid),
        .char_ready_i (char_ready),
        .char_data_o  (char_data),
        .sim_done_o   (sim_done),
        .sim_pass_o   (sim_pass)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic logic [1:0] model_resp(input logic [39:0] a, input logic [3:0] len,
                                              input logic [1:0] burst);
        if (len == 0 && burst == 2'b01 && (a == CON || a == CTRL)) return 2'b00;
        return 2'b10;
    endfunction

    task automatic model_beat(input logic [39:0] a, input logic [3:0] len, input logic [1:0] burst,
                              input logic [127:0] d, input logic [15:0] s);
        logic [15:0] m;
        if (model_resp(a, len, burst) != 2'b00) return;
        if (a == CON) begin
            for (int k = 0; k < 4; k++) begin
                m = 16'hF << (4 * k);
                if (s == m) exp_q.push_back(d[32 * k +: 8]);
            end
        end else if (s[7:0] == 8'hFF && !m_done) begin
            if (d[63:0] == PASSV) begin
                m_done = 1'b1;
                m_pass = 1'b1;
            end else if (d[63:0] == FAILV) begin
                m_done = 1'b1;
                m_pass = 1'b0;
            end
        end
    endtask

    task automatic aw_phase(input logic [39:0] a, input logic [7:0] id, input logic [3:0] len,
                            input logic [1:0] burst);
        bit ok = 1'b0;
        awvalid = 1'b1;
        awaddr  = a;
        awid    = id;
        awlen   = len;
        awburst = burst;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clk);
            if (awready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        if (!ok) timeout("aw_handshake");
    endtask

    task automatic w_beat(input logic [39:0] a, input logic [3:0] len, input logic [1:0] burst,
                          input logic [127:0] d, input logic [15:0] s, input logic last);
        bit ok = 1'b0;
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        wlast  = last;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clk);
            if (wready) begin
                ok = 1'b1;
                model_beat(a, len, burst, d, s);
            end
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (!ok) timeout("w_handshake");
    endtask

    // bready held low for the first response cycle to confirm bvalid/bid/bresp hold.
    task automatic b_phase(output logic [1:0] resp, output logic [7:0] rid);
        bit ok = 1'b0;
        logic [1:0] r0;
        logic [7:0] i0;
        @(negedge clk);
        check("b_latency", bvalid, 1'b1);
        r0 = bresp;
        i0 = bid;
        @(posedge clk);
        #1;
        bready = 1'b1;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge clk);
            if (bvalid) ok = 1'b1;
            resp = bresp;
            rid  = bid;
            @(posedge clk);
            #1;
        end
        bready = 1'b0;
        if (!ok) timeout("b_handshake");
        else check("b_stable", {r0, i0}, {resp, rid});
    endtask

    task automatic write_txn(input logic [39:0] a, input logic [7:0] id, input logic [3:0] len,
                             input logic [1:0] burst, input logic [127:0] d, input logic [15:0] s,
                             output logic [1:0] resp, output logic [7:0] rid);
        aw_phase(a, id, len, burst);
        for (int b = 0; b <= int'(len); b++) w_beat(a, len, burst, d, s, b == int'(len));
        b_phase(resp, rid);
    endtask

    task automatic drain();
        bit ok;
        char_ready = 1'b1;
        while (exp_q.size() > 0) begin
            ok = 1'b0;
            for (int i = 0; i < TMO && !ok; i++) begin
                @(negedge clk);
                if (char_valid) begin
                    ok = 1'b1;
                    check("char_order", char_data, exp_q.pop_front());
                end
                @(posedge clk);
                #1;
            end
            if (!ok) begin
                timeout("char_valid");
                exp_q.delete();
            end
        end
        char_ready = 1'b0;
        @(negedge clk);
        check("fifo_empty", char_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_awready"}, awready, 1'b0);
        check({tag, "_wready"}, wready, 1'b0);
        check({tag, "_bvalid"}, bvalid, 1'b0);
        check({tag, "_char_valid"}, char_valid, 1'b0);
        check({tag, "_sim_done"}, sim_done, 1'b0);
        check({tag, "_sim_pass"}, sim_pass, 1'b0);
        check({tag, "_bresp_bid"}, {bresp, bid}, 10'd0);
        check({tag, "_char_data"}, char_data, 8'd0);
    endtask

    typedef struct {
        logic [39:0]  addr;
        logic [7:0]   id;
        logic [3:0]   len;
        logic [1:0]   burst;
        logic [127:0] data;
        logic [15:0]  strb;
        logic [1:0]   resp;
        bit           has_char;
        logic [7:0]   chr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [1:0]   resp;
        logic [7:0]   rid;
        logic [127:0] d;
        logic [63:0]  t64;
        logic [39:0]  a;
        logic [15:0]  s;
        logic [3:0]   len;
        logic [1:0]   burst;
        logic [7:0]   id;
        int           r;

        vecs[0] = '{CON,  8'h11, 4'd0, 2'b01, 128'hCAFE_0000_1111_2222_3333_4444_5555_AA41,
                    16'h000F, 2'b00, 1'b1, 8'h41};
        vecs[1] = '{CON,  8'h22, 4'd0, 2'b01, 128'h0101_0202_0303_045A_0505_0606_0707_0841,
                    16'h0F00, 2'b00, 1'b1, 8'h5A};
        vecs[2] = '{CON,  8'h33, 4'd0, 2'b01, 128'h41, 16'h00FF, 2'b00, 1'b0, 8'h00};
        vecs[3] = '{CON,  8'h44, 4'd0, 2'b01, 128'h0000_007E_0000_0033_0000_0022_0000_0011,
                    16'hF000, 2'b00, 1'b1, 8'h7E};
        vecs[4] = '{CON,  8'h55, 4'd0, 2'b01, 128'h41, 16'h0000, 2'b00, 1'b0, 8'h00};
        vecs[5] = '{CTRL, 8'h66, 4'd0, 2'b01, 128'h1234, 16'h00FF, 2'b00, 1'b0, 8'h00};
        vecs[6] = '{BAD,  8'h77, 4'd0, 2'b01, 128'h41, 16'h000F, 2'b10, 1'b0, 8'h00};
        vecs[7] = '{CON,  8'h88, 4'd0, 2'b00, 128'h41, 16'h000F, 2'b10, 1'b0, 8'h00};
        vecs[8] = '{CON,  8'h99, 4'd3, 2'b01, 128'h41, 16'h000F, 2'b10, 1'b0, 8'h00};
        vecs[9] = '{CTRL, 8'hAA, 4'd1, 2'b01, {64'h0, PASSV}, 16'hFFFF, 2'b10, 1'b0, 8'h00};

        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            write_txn(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].burst, vecs[i].data,
                      vecs[i].strb, resp, rid);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
            check($sformatf("vec%0d_bid", i), rid, vecs[i].id);
            @(negedge clk);
            check($sformatf("vec%0d_char_valid", i), char_valid, vecs[i].has_char);
            if (vecs[i].has_char) check($sformatf("vec%0d_char", i), char_data, vecs[i].chr);
            @(posedge clk);
            #1;
            drain();
        end
        check("no_done_yet", sim_done, 1'b0);

        // Pass magic, then fail magic must not override
        write_txn(CTRL, 8'h01, 4'd0, 2'b01, {64'hFFFF, PASSV}, 16'h00FF, resp, rid);
        check("pass_resp", resp, 2'b00);
        check("pass_done", {sim_done, sim_pass}, 2'b11);
        write_txn(CTRL, 8'h02, 4'd0, 2'b01, {64'h0, FAILV}, 16'h00FF, resp, rid);
        check("sticky_pass", {sim_done, sim_pass}, 2'b11);

        // Fill FIFO with 1..8, ninth beat stalls until one pop
        for (int c = 1; c <= 8; c++) begin
            d = 128'(c);
            write_txn(CON, 8'(c), 4'd0, 2'b01, d, 16'h000F, resp, rid);
            check("fill_resp", resp, 2'b00);
        end
        aw_phase(CON, 8'h09, 4'd0, 2'b01);
        wvalid = 1'b1;
        wdata  = 128'd9;
        wstrb  = 16'h000F;
        wlast  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("full_stall", wready, 1'b0);
            @(posedge clk);
            #1;
        end
        char_ready = 1'b1;
        @(negedge clk);
        check("full_pop_wready", wready, 1'b1);
        check("full_pop_char", char_data, exp_q.pop_front());
        model_beat(CON, 4'd0, 2'b01, 128'd9, 16'h000F);
        @(posedge clk);
        #1;
        char_ready = 1'b0;
        wvalid = 1'b0;
        wlast  = 1'b0;
        b_phase(resp, rid);
        check("ninth_resp", {resp, rid}, {2'b00, 8'h09});
        check("queued_count", exp_q.size(), 8);
        check("queued_last", exp_q[7], 8'd9);
        drain();

        // Reset during DATA with three characters queued
        for (int c = 0; c < 3; c++) begin
            write_txn(CON, 8'h30, 4'd0, 2'b01, 128'h78 + 128'(c), 16'h000F, resp, rid);
        end
        aw_phase(CON, 8'h5C, 4'd0, 2'b01);
        rst_b = 1'b0;
        #2;
        check_zero("midreset");
        exp_q.delete();
        m_done = 1'b0;
        m_pass = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_reset_awready", awready, 1'b1);
        check("post_reset_empty", char_valid, 1'b0);
        @(posedge clk);
        #1;

        // Randomized transactions against the model
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            t64 = {$urandom(), $urandom()};
            a = (r < 4) ? CON : (r < 7) ? CTRL : (r < 8) ? BAD : t64[39:0];
            len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
            burst = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01;
            id = 8'($urandom());
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            r = $urandom_range(0, 5);
            if (a == CTRL) begin
                s = (r < 4) ? 16'hFFFF : 16'($urandom());
                r = $urandom_range(0, 5);
                if (r == 0) d[63:0] = PASSV;
                if (r == 1) d[63:0] = FAILV;
            end else begin
                s = (r < 4) ? (16'hF << (4 * r)) : (r == 4) ? 16'h00FF : 16'($urandom());
            end
            write_txn(a, id, len, burst, d, s, resp, rid);
            check("rand_bresp", resp, model_resp(a, len, burst));
            check("rand_bid", rid, id);
            check("rand_sim", {sim_done, sim_pass}, {m_done, m_pass});
            if (exp_q.size() >= 6) drain();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

endmodule
